// File: rtl/exhaustive_adder_checker_if.sv
// Operand/result bus between the exhaustive checker and the adder it sweeps.
// The checker drives operands (master); the adder returns sum and carry (slave).
interface exhaustive_adder_checker_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  modport master (
    output a, b, cin,
    input  dut_sum, dut_cout
  );

  modport slave (
    input  a, b, cin,
    output dut_sum, dut_cout
  );
endinterface

// File: rtl/exhaustive_adder_checker.sv
// Sweeps every {cin,b,a} vector into an external adder, waits SETTLE cycles,
// checks {cout,sum} against a golden sum and records mismatch statistics.
module exhaustive_adder_checker #(
  parameter int WIDTH        = 4,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  exhaustive_adder_checker_if.master  bus,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [2*WIDTH+1:0]          err_count,
  output logic [2*WIDTH:0]            first_fail,
  output logic [WIDTH:0]              first_got
);

  localparam int IW = 2*WIDTH + 1;
  localparam int EW = 2*WIDTH + 2;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            error_q, error_d;
  logic [EW-1:0]   errcnt_q, errcnt_d;
  logic [IW-1:0]   ff_q, ff_d;
  logic [WIDTH:0]  fg_q, fg_d;

  logic [WIDTH:0]  golden;
  logic [WIDTH:0]  got;
  logic            mismatch;
  logic            last_vec;

  assign golden   = {1'b0, idx_q[WIDTH-1:0]} + {1'b0, idx_q[2*WIDTH-1:WIDTH]}
                  + {{WIDTH{1'b0}}, idx_q[IW-1]};
  assign got      = {bus.dut_cout, bus.dut_sum};
  assign mismatch = (got != golden);
  assign last_vec = &idx_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    errcnt_d = errcnt_q;
    ff_d     = ff_q;
    fg_d     = fg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d    = '0;
          cnt_d    = SETTLE_C;
          error_d  = 1'b0;
          errcnt_d = '0;
          ff_d     = '0;
          fg_d     = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // The edge that takes the counter to zero is the one that enters CHECK.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          error_d  = 1'b1;
          errcnt_d = errcnt_q + EW'(1);
          if (errcnt_q == '0) begin
            ff_d = idx_q;
            fg_d = got;
          end
        end
        if (last_vec || ((STOP_ON_FAIL != 0) && mismatch)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          cnt_d   = SETTLE_C;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
      errcnt_q <= '0;
      ff_q     <= '0;
      fg_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
      errcnt_q <= errcnt_d;
      ff_q     <= ff_d;
      fg_q     <= fg_d;
    end
  end

  assign bus.a      = idx_q[WIDTH-1:0];
  assign bus.b      = idx_q[2*WIDTH-1:WIDTH];
  assign bus.cin    = idx_q[IW-1];
  assign busy       = (state_q == WAIT) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign error      = error_q;
  assign err_count  = errcnt_q;
  assign first_fail = ff_q;
  assign first_got  = fg_q;

endmodule
